// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_if
//  Description : Fetch-side and memory-controller-side handshake bundle for
//                the instruction cache. The cache uses the slave modport; the
//                fetch stage / memory controller environment uses master.
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_if;
  // fetch stage <-> cache
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  // cache <-> memory controller
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [31:0] mc_data;

  modport slave (
    input  if_req, if_addr, mc_valid, mc_data,
    output if_valid, if_inst, mc_req, mc_addr
  );

  modport master (
    output if_req, if_addr, mc_valid, mc_data,
    input  if_valid, if_inst, mc_req, mc_addr
  );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped, read-only instruction cache, one 32-bit word
//                per line. Hits return a registered instruction one cycle
//                after the request; misses fetch the word from the memory
//                controller, fill the line and return it two cycles after the
//                memory response. Addresses with [17:16]==2'b11 are I/O and
//                are never allocated.
//                Optional macro ICACHE_PERF_EN adds hit/miss counters.
//  Revision    : 1.0  initial release
// ============================================================================
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_BITS  = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy_i,
  input  logic        flush_i,
  icache_if.slave     bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Storage: data/tag arrays carry no reset, only the valid vector does.
  // --------------------------------------------------------------------------
  logic [31:0]      data_q  [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic [LINES-1:0] valid_q;

  // FSM and registered outputs
  state_t                 state_q;
  logic                   if_valid_q;
  logic [31:0]            if_inst_q;
  logic                   mc_req_q;
  logic [31:0]            mc_addr_q;
  logic                   drop_q;     // response of the in-flight miss must be suppressed
  logic [INDEX_BITS-1:0]  miss_idx_q;
  logic [TAG_W-1:0]       miss_tag_q;
  logic                   miss_io_q;

  // --------------------------------------------------------------------------
  // Lookup of the presented fetch address
  // --------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_io;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_fill;
  logic                  w_unused_addr;

  assign w_idx  = bus.if_addr[INDEX_BITS+1:2];
  assign w_tag  = bus.if_addr[ADDR_BITS-1:INDEX_BITS+2];
  // I/O space is decoded on fixed bits independent of ADDR_BITS
  assign w_io   = (bus.if_addr[17:16] == 2'b11);
  assign w_hit  = !w_io && valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  // byte offset within the word is irrelevant to a word cache
  assign w_unused_addr = ^bus.if_addr[1:0];

  // A request counts as taken only when sampled in IDLE, unflushed, with rdy
  assign w_accept = rdy_i && (state_q == S_IDLE) && bus.if_req && !flush_i;
  // Refill write happens on the memory response even if the fetch was flushed
  assign w_fill   = rdy_i && (state_q == S_MISS) && bus.mc_valid && !miss_io_q;

  // Line data and tag are written on refill; no reset needed since valid gates them
  always_ff @(posedge clk) begin
    if (w_fill) begin
      data_q[miss_idx_q] <= bus.mc_data;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

  // Valid vector: cleared by reset, set when a cacheable line is refilled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (w_fill) begin
      valid_q[miss_idx_q] <= 1'b1;
    end
  end

  // Control FSM with registered fetch and memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'd0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= 32'd0;
      drop_q     <= 1'b0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      miss_io_q  <= 1'b0;
    end else if (rdy_i) begin
      case (state_q)
        S_IDLE: begin
          if_valid_q <= 1'b0;
          drop_q     <= 1'b0;
          if (bus.if_req && !flush_i) begin
            if (w_hit) begin
              if_valid_q <= 1'b1;
              if_inst_q  <= data_q[w_idx];
            end else begin
              mc_req_q   <= 1'b1;
              mc_addr_q  <= {bus.if_addr[31:2], 2'b00};
              miss_idx_q <= w_idx;
              miss_tag_q <= w_tag;
              miss_io_q  <= w_io;
              state_q    <= S_MISS;
            end
          end
        end

        S_MISS: begin
          if (flush_i) begin
            drop_q <= 1'b1;
          end
          if (bus.mc_valid) begin
            mc_req_q  <= 1'b0;
            if_inst_q <= bus.mc_data;
            state_q   <= S_RESP;
          end
        end

        S_RESP: begin
          // A flush arriving here also predates the response, so it suppresses too
          if_valid_q <= !(drop_q || flush_i);
          drop_q     <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          if_valid_q <= 1'b0;
          mc_req_q   <= 1'b0;
          drop_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_valid = if_valid_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.mc_req   = mc_req_q;
  assign bus.mc_addr  = mc_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign hit_cnt_d  = hit_cnt_q  + {31'd0, (w_accept &&  w_hit)};
  assign miss_cnt_d = miss_cnt_q + {31'd0, (w_accept && !w_hit)};

  // Performance counters; wrap naturally and hold while rdy is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (rdy_i) begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Self-checking bench for icache. A transaction-level cache
//                model predicts hit/miss per request and records, per cycle,
//                whether if_valid/if_inst and mc_req/mc_addr must be seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache;
  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic flush;
  icache_if bus();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdy_i   (rdy),
    .flush_i (flush),
    .bus     (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  // expectations keyed by cycle: presence means the output must be high
  logic [31:0] e_inst [int];
  logic [31:0] e_mca  [int];

  // cache model: per-line valid/tag/data
  bit          mv [128];
  logic [7:0]  mt [128];
  logic [31:0] md [128];
  int n_hit = 0, n_miss = 0;

  // backing memory, keyed by word address
  logic [31:0] mem [int];

  int refills = 0;
  logic mr_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    int k;
    k = int'(a[31:2]);
    if (mem.exists(k)) return mem[k];
    return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0;
    tick();
  endtask

  // per-cycle output comparison against the model's expectations
  always @(negedge clk) begin
    if (bus.mc_req && !mr_prev) refills++;
    mr_prev = bus.mc_req;
    if (checking) begin
      if (e_inst.exists(cyc)) begin
        chk("if_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("if_inst", bus.if_inst, e_inst[cyc]);
      end else begin
        chk("if_valid", {31'd0, bus.if_valid}, 32'd0);
      end
      if (e_mca.exists(cyc)) begin
        chk("mc_req", {31'd0, bus.mc_req}, 32'd1);
        chk("mc_addr", bus.mc_addr, e_mca[cyc]);
      end else begin
        chk("mc_req", {31'd0, bus.mc_req}, 32'd0);
      end
    end
  end

  // One fetch. fl: 0 none, 1 flush one cycle before mc_valid, 2 flush with mc_valid.
  // rdy_lo: rdy held low for that many cycles right after mc_req rises.
  // Returns in the cycle where if_valid is (or would be) visible.
  task automatic fetch(input logic [31:0] a, input int lat, input int fl, input int rdy_lo);
    int c, m;
    logic [6:0] ix;
    logic [7:0] tg;
    bit io, hit;
    c   = cyc;
    ix  = a[8:2];
    tg  = a[16:9];
    io  = (a[17:16] == 2'b11);
    hit = !io && mv[ix] && (mt[ix] == tg);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    if (hit) begin
      n_hit++;
      e_inst[c+1] = md[ix];
      tick();
    end else begin
      n_miss++;
      m = c + 1 + lat + rdy_lo;
      for (int k = c + 1; k <= m; k++) e_mca[k] = {a[31:2], 2'b00};
      if (fl == 0) e_inst[m+2] = memw(a);
      tick();
      while (cyc < m) begin
        rdy = !(cyc <= c + rdy_lo);
        if (fl == 1 && cyc == m - 1) begin
          flush = 1'b1;
          bus.if_req = 1'b0;
        end
        tick();
        flush = 1'b0;
        rdy   = 1'b1;
      end
      bus.mc_valid = 1'b1;
      bus.mc_data  = memw(a);
      if (fl == 2) begin
        flush = 1'b1;
        bus.if_req = 1'b0;
      end
      tick();
      bus.mc_valid = 1'b0;
      bus.mc_data  = 32'd0;
      flush = 1'b0;
      if (!io) begin
        mv[ix] = 1'b1;
        mt[ix] = tg;
        md[ix] = memw(a);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    mem[int'(32'h1000 >> 2)] = 32'h0000_0013;
    rst_n = 1'b0;
    rdy   = 1'b1;
    flush = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.mc_valid = 1'b0;
    bus.mc_data  = 32'd0;
    repeat (3) tick();
    chk("reset_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("reset_if_inst",  bus.if_inst, 32'd0);
    chk("reset_mc_req",   {31'd0, bus.mc_req}, 32'd0);
    chk("reset_mc_addr",  bus.mc_addr, 32'd0);
    rst_n = 1'b1;
    tick();
    checking = 1'b1;

    // cold miss
    r0 = refills;
    fetch(32'h0000_1000, 3, 0, 0);
    chk("cold_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("cold_inst", bus.if_inst, 32'h0000_0013);
    chk("cold_refills", refills - r0, 32'd1);

    // back-to-back hits, including an unaligned byte address in the same word
    fetch(32'h0000_1000, 3, 0, 0);
    chk("hit_inst", bus.if_inst, 32'h0000_0013);
    fetch(32'h0000_1002, 3, 0, 0);
    chk("hit2_inst", bus.if_inst, 32'h0000_0013);
    chk("hit_refills", refills - r0, 32'd1);
    idle();

    // conflict on index 0
    fetch(32'h0000_1200, 2, 0, 0);
    idle();
    r0 = refills;
    fetch(32'h0000_1000, 2, 0, 0);
    fetch(32'h0000_1200, 2, 0, 0);
    fetch(32'h0000_1000, 2, 0, 0);
    chk("conflict_inst", bus.if_inst, 32'h0000_0013);
    chk("conflict_refills", refills - r0, 32'd3);
    idle();

    // flush one cycle before the memory response, then re-fetch hits
    fetch(32'h0000_2000, 3, 1, 0);
    chk("flushed_no_valid", {31'd0, bus.if_valid}, 32'd0);
    idle();
    r0 = refills;
    fetch(32'h0000_2000, 3, 0, 0);
    chk("post_flush_hit", bus.if_inst, 32'hC0DE_2000);
    chk("post_flush_refills", refills - r0, 32'd0);
    idle();

    // flush coincident with the memory response
    fetch(32'h0000_2404, 2, 2, 0);
    idle();
    fetch(32'h0000_2404, 2, 0, 0);
    chk("flush_same_hit", bus.if_inst, 32'hC0DE_2404);
    idle();

    // flush in IDLE cancels a request that would hit
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_1000;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.if_req = 1'b0;
    chk("idle_flush_no_valid", {31'd0, bus.if_valid}, 32'd0);
    tick();

    // I/O address is never allocated
    r0 = refills;
    fetch(32'h0003_0000, 2, 0, 0);
    fetch(32'h0003_0000, 2, 0, 0);
    chk("io_refills", refills - r0, 32'd2);
    idle();

    // rdy low for 5 cycles during MISS delays the response by exactly 5
    r0 = cyc;
    fetch(32'h0000_4000, 3, 0, 5);
    chk("rdy_latency", cyc - r0, 32'd11);
    chk("rdy_valid", {31'd0, bus.if_valid}, 32'd1);
    idle();

`ifdef ICACHE_PERF_EN
    chk("perf_hit", hit_cnt, n_hit);
    chk("perf_miss", miss_cnt, n_miss);
`endif

    // reset during a refill
    checking = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_3000;
    tick();
    chk("pre_reset_mc_req", {31'd0, bus.mc_req}, 32'd1);
    chk("pre_reset_mc_addr", bus.mc_addr, 32'h0000_3000);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset_mc_req", {31'd0, bus.mc_req}, 32'd0);
    chk("async_reset_valid", {31'd0, bus.if_valid}, 32'd0);
    bus.if_req = 1'b0;
    for (int i = 0; i < 128; i++) mv[i] = 1'b0;
    n_hit  = 0;
    n_miss = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
`ifdef ICACHE_PERF_EN
    chk("perf_hit_reset", hit_cnt, 32'd0);
    chk("perf_miss_reset", miss_cnt, 32'd0);
`endif
    checking = 1'b1;
    r0 = refills;
    fetch(32'h0000_1000, 2, 0, 0);
    chk("post_reset_miss", refills - r0, 32'd1);
    chk("post_reset_inst", bus.if_inst, 32'h0000_0013);
    idle();
    tick();
    checking = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
